stg_hazard_ctl: RTL and testbench

- Central pipeline sequencer for the amber core. It generates stall, flush and bubble controls around stg_ex and the front stages (IA..ID).
- Sources: EX-stage branch resolution, ID/EX load-use hazards, multi-cycle EX ops and memory wait.
- Holds the run/busy/flush state machine plus stall accounting.
- Sits beside the stage chain; drives each stage's iw_stall/iw_flush.

---
 rtl/stg_hazard_ctl_pkg.sv | 13 +
 rtl/stg_hazard_ctl_if.sv | 46 ++++
 rtl/stg_hazard_ctl_hz_luse_det.sv | 20 ++
 rtl/stg_hazard_ctl.sv | 144 ++++++++++++++
 tb/tb_stg_hazard_ctl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/stg_hazard_ctl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: GP index width and FSM encoding.
package stg_hazard_ctl_pkg;

    localparam int GP_IDX_W   = 4;
    localparam int HBIT_HZ_ST = 1;

    typedef enum logic [HBIT_HZ_ST:0] {
        HZ_RUN     = 2'd0,
        HZ_MC_BUSY = 2'd1,
        HZ_FLUSH   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/stg_hazard_ctl_if.sv
// Hazard-control bundle between the stage chain and the sequencer.
interface stg_hazard_ctl_if
    import stg_hazard_ctl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [GP_IDX_W-1:0] iw_id_src_gp;
    logic                iw_id_src_gp_re;
    logic [GP_IDX_W-1:0] iw_id_tgt_gp;
    logic                iw_id_tgt_gp_re;
    logic [GP_IDX_W-1:0] iw_ex_tgt_gp;
    logic                iw_ex_tgt_gp_we;
    logic                iw_ex_is_load;
    logic                iw_ex_branch_taken;
    logic                iw_ex_mc_start;
    logic                iw_ex_mc_done;
    logic                iw_mem_wait;
    logic                iw_cnt_clr;

    logic                ow_stall_front;
    logic                ow_stall_ex;
    logic                ow_stall_back;
    logic                ow_flush_front;
    logic                ow_bubble_ex;
    logic [1:0]          ow_state;
    logic                ow_mc_timeout;
    logic                ow_err;
    logic [CNT_W-1:0]    ow_stall_cnt;

    // The sequencer side: consumes pipeline status, drives stage controls.
    modport slave (
        input  iw_id_src_gp, iw_id_src_gp_re, iw_id_tgt_gp, iw_id_tgt_gp_re,
               iw_ex_tgt_gp, iw_ex_tgt_gp_we, iw_ex_is_load, iw_ex_branch_taken,
               iw_ex_mc_start, iw_ex_mc_done, iw_mem_wait, iw_cnt_clr,
        output ow_stall_front, ow_stall_ex, ow_stall_back, ow_flush_front,
               ow_bubble_ex, ow_state, ow_mc_timeout, ow_err, ow_stall_cnt
    );

    modport master (
        output iw_id_src_gp, iw_id_src_gp_re, iw_id_tgt_gp, iw_id_tgt_gp_re,
               iw_ex_tgt_gp, iw_ex_tgt_gp_we, iw_ex_is_load, iw_ex_branch_taken,
               iw_ex_mc_start, iw_ex_mc_done, iw_mem_wait, iw_cnt_clr,
        input  ow_stall_front, ow_stall_ex, ow_stall_back, ow_flush_front,
               ow_bubble_ex, ow_state, ow_mc_timeout, ow_err, ow_stall_cnt
    );
endinterface

// File: rtl/stg_hazard_ctl_hz_luse_det.sv
// Combinational load-use comparator: a load in EX whose target is read by ID.
module hz_luse_det
    import stg_hazard_ctl_pkg::*;
(
    input  logic [GP_IDX_W-1:0] iw_id_src_gp,
    input  logic                iw_id_src_gp_re,
    input  logic [GP_IDX_W-1:0] iw_id_tgt_gp,
    input  logic                iw_id_tgt_gp_re,
    input  logic [GP_IDX_W-1:0] iw_ex_tgt_gp,
    input  logic                iw_ex_tgt_gp_we,
    input  logic                iw_ex_is_load,
    output logic                ow_hazard
);
    logic src_hit;
    logic tgt_hit;

    assign src_hit   = iw_id_src_gp_re & (iw_id_src_gp == iw_ex_tgt_gp);
    assign tgt_hit   = iw_id_tgt_gp_re & (iw_id_tgt_gp == iw_ex_tgt_gp);
    assign ow_hazard = iw_ex_is_load & iw_ex_tgt_gp_we & (src_hit | tgt_hit);
endmodule

// File: rtl/stg_hazard_ctl.sv
// Central pipeline sequencer: Mealy decode of run/busy/flush state into stage stall,
// flush and bubble controls, with a saturating stall-cycle counter.
module stg_hazard_ctl
    import stg_hazard_ctl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 16
) (
    input logic             iw_clk,
    input logic             iw_rst_n,
    stg_hazard_ctl_if.slave hz
);
    localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] MC_LAST = 8'(MC_TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    hz_state_e        state_q, state_d;
    logic [2:0]       fl_cnt_q, fl_cnt_d;
    logic [7:0]       mc_cnt_q, mc_cnt_d;
    logic             err_q, err_set;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             luse;

    logic stall_front, stall_ex, stall_back, flush_front, bubble_ex, mc_timeout;

    hz_luse_det u_luse (
        .iw_id_src_gp    (hz.iw_id_src_gp),
        .iw_id_src_gp_re (hz.iw_id_src_gp_re),
        .iw_id_tgt_gp    (hz.iw_id_tgt_gp),
        .iw_id_tgt_gp_re (hz.iw_id_tgt_gp_re),
        .iw_ex_tgt_gp    (hz.iw_ex_tgt_gp),
        .iw_ex_tgt_gp_we (hz.iw_ex_tgt_gp_we),
        .iw_ex_is_load   (hz.iw_ex_is_load),
        .ow_hazard       (luse)
    );

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q     <= HZ_RUN;
            fl_cnt_q    <= '0;
            mc_cnt_q    <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            fl_cnt_q <= fl_cnt_d;
            mc_cnt_q <= mc_cnt_d;
            if (err_set) err_q <= 1'b1;
            if (hz.iw_cnt_clr)
                stall_cnt_q <= '0;
            else if (stall_front)
                stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    // Memory wait freezes every sequence in place, so nothing advances under it.
    always_comb begin
        state_d  = state_q;
        fl_cnt_d = fl_cnt_q;
        mc_cnt_d = mc_cnt_q;
        err_set  = 1'b0;
        if (!hz.iw_mem_wait) begin
            case (state_q)
                HZ_MC_BUSY: begin
                    mc_cnt_d = mc_cnt_q + 8'd1;
                    if (hz.iw_ex_mc_done || mc_cnt_q == MC_LAST) state_d = HZ_RUN;
                end
                HZ_FLUSH: begin
                    fl_cnt_d = fl_cnt_q - 3'd1;
                    if (fl_cnt_q <= 3'd1) state_d = HZ_RUN;
                end
                default: begin
                    state_d = HZ_RUN;
                    if (hz.iw_ex_branch_taken) begin
                        err_set = hz.iw_ex_mc_start;
                        if (FLUSH_CYCLES > 1) begin
                            state_d  = HZ_FLUSH;
                            fl_cnt_d = FL_INIT;
                        end
                    end else if (hz.iw_ex_mc_start) begin
                        state_d  = HZ_MC_BUSY;
                        mc_cnt_d = '0;
                    end
                end
            endcase
        end
    end

    // Outputs are forced low while reset is held, whatever the inputs do.
    always_comb begin
        stall_front = 1'b0;
        stall_ex    = 1'b0;
        stall_back  = 1'b0;
        flush_front = 1'b0;
        bubble_ex   = 1'b0;
        mc_timeout  = 1'b0;
        if (!iw_rst_n) begin
            stall_front = 1'b0;
        end else if (hz.iw_mem_wait) begin
            stall_front = 1'b1;
            stall_ex    = 1'b1;
            stall_back  = 1'b1;
        end else begin
            case (state_q)
                HZ_MC_BUSY: begin
                    if (!hz.iw_ex_mc_done) begin
                        if (mc_cnt_q == MC_LAST) begin
                            mc_timeout = 1'b1;
                        end else begin
                            stall_front = 1'b1;
                            stall_ex    = 1'b1;
                        end
                    end
                end
                HZ_FLUSH: flush_front = 1'b1;
                default: begin
                    if (hz.iw_ex_branch_taken) begin
                        flush_front = 1'b1;
                    end else if (hz.iw_ex_mc_start) begin
                        stall_front = 1'b1;
                        stall_ex    = 1'b1;
                    end else if (luse) begin
                        stall_front = 1'b1;
                        bubble_ex   = 1'b1;
                    end
                end
            endcase
        end
    end

    assign hz.ow_stall_front = stall_front;
    assign hz.ow_stall_ex    = stall_ex;
    assign hz.ow_stall_back  = stall_back;
    assign hz.ow_flush_front = flush_front;
    assign hz.ow_bubble_ex   = bubble_ex;
    assign hz.ow_mc_timeout  = mc_timeout;
    assign hz.ow_state       = state_q;
    assign hz.ow_err         = err_q;
    assign hz.ow_stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_stg_hazard_ctl.sv
// Bench for stg_hazard_ctl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural model.
module tb_stg_hazard_ctl;
    import stg_hazard_ctl_pkg::*;

    localparam int FLUSH_CYCLES = 3;
    localparam int MC_TIMEOUT   = 8;
    localparam int CNT_W        = 5;
    localparam int CMAX         = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    stg_hazard_ctl_if #(.CNT_W(CNT_W)) hz ();

    stg_hazard_ctl #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MC_TIMEOUT   (MC_TIMEOUT),
        .CNT_W        (CNT_W)
    ) dut (
        .iw_clk   (clk),
        .iw_rst_n (rst_n),
        .hz       (hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining flush cycles, multi-cycle age, stall tally.
    int m_fl_left = 0;
    int m_mc_age  = 0;
    bit m_busy    = 0;
    bit m_err     = 0;
    int m_cnt     = 0;

    always @(negedge clk) begin : cmp
        bit e_sf, e_se, e_sb, e_fl, e_bub, e_to, luse;
        int e_state, e_cnt;
        bit e_err;
        e_sf = 0; e_se = 0; e_sb = 0; e_fl = 0; e_bub = 0; e_to = 0;
        if (!rst_n) begin
            m_fl_left = 0; m_mc_age = 0; m_busy = 0; m_err = 0; m_cnt = 0;
        end
        e_state = m_busy ? 1 : (m_fl_left > 0 ? 2 : 0);
        e_err   = m_err;
        e_cnt   = m_cnt;
        luse = hz.iw_ex_is_load && hz.iw_ex_tgt_gp_we &&
               ((hz.iw_id_src_gp_re && hz.iw_id_src_gp == hz.iw_ex_tgt_gp) ||
                (hz.iw_id_tgt_gp_re && hz.iw_id_tgt_gp == hz.iw_ex_tgt_gp));
        if (rst_n) begin
            if (hz.iw_mem_wait) begin
                e_sf = 1; e_se = 1; e_sb = 1;
            end else if (m_fl_left > 0) begin
                e_fl = 1;
                m_fl_left--;
            end else if (m_busy) begin
                if (hz.iw_ex_mc_done) m_busy = 0;
                else if (m_mc_age == MC_TIMEOUT - 1) begin e_to = 1; m_busy = 0; end
                else begin e_sf = 1; e_se = 1; m_mc_age++; end
            end else if (hz.iw_ex_branch_taken) begin
                e_fl = 1;
                m_fl_left = FLUSH_CYCLES - 1;
                if (hz.iw_ex_mc_start) m_err = 1;
            end else if (hz.iw_ex_mc_start) begin
                e_sf = 1; e_se = 1;
                m_busy = 1; m_mc_age = 0;
            end else if (luse) begin
                e_sf = 1; e_bub = 1;
            end
            if (hz.iw_cnt_clr) m_cnt = 0;
            else if (e_sf) m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        end
        check("m_stall_front", 32'(hz.ow_stall_front), 32'(e_sf));
        check("m_stall_ex",    32'(hz.ow_stall_ex),    32'(e_se));
        check("m_stall_back",  32'(hz.ow_stall_back),  32'(e_sb));
        check("m_flush_front", 32'(hz.ow_flush_front), 32'(e_fl));
        check("m_bubble_ex",   32'(hz.ow_bubble_ex),   32'(e_bub));
        check("m_mc_timeout",  32'(hz.ow_mc_timeout),  32'(e_to));
        check("m_state",       32'(hz.ow_state),       32'(e_state));
        check("m_err",         32'(hz.ow_err),         32'(e_err));
        check("m_stall_cnt",   32'(hz.ow_stall_cnt),   32'(e_cnt));
    end

    task automatic clr_in();
        hz.iw_id_src_gp = '0;  hz.iw_id_src_gp_re = 0;
        hz.iw_id_tgt_gp = '0;  hz.iw_id_tgt_gp_re = 0;
        hz.iw_ex_tgt_gp = '0;  hz.iw_ex_tgt_gp_we = 0;
        hz.iw_ex_is_load = 0;  hz.iw_ex_branch_taken = 0;
        hz.iw_ex_mc_start = 0; hz.iw_ex_mc_done = 0;
        hz.iw_mem_wait = 0;    hz.iw_cnt_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_luse(input int ex_tgt, input int src, input bit is_load);
        hz.iw_ex_is_load = is_load; hz.iw_ex_tgt_gp_we = 1;
        hz.iw_ex_tgt_gp = GP_IDX_W'(ex_tgt);
        hz.iw_id_src_gp = GP_IDX_W'(src); hz.iw_id_src_gp_re = 1;
    endtask

    task automatic run_mc_timeout(input int wait_from, input int wait_len,
                                  input int exp_stalls, input int exp_to_at);
        int stalls, to_cnt, to_at;
        stalls = 0; to_cnt = 0; to_at = -1;
        for (int i = 0; i < 16; i++) begin
            hz.iw_ex_mc_start = (i == 0);
            hz.iw_mem_wait = (i >= wait_from && i < wait_from + wait_len);
            #1;
            if (hz.ow_stall_front) stalls++;
            if (hz.ow_mc_timeout) begin to_cnt++; to_at = i; end
            tick();
        end
        clr_in();
        check("to_stalls", 32'(stalls), 32'(exp_stalls));
        check("to_pulses", 32'(to_cnt), 32'd1);
        check("to_cycle",  32'(to_at),  32'(exp_to_at));
        check("to_state",  32'(hz.ow_state), 32'd0);
    endtask

    initial begin
        int stalls;
        rst_n = 0;
        clr_in();
        hz.iw_ex_branch_taken = 1;
        #7;
        check("rst_flush",  32'(hz.ow_flush_front), 32'd0);
        check("rst_state",  32'(hz.ow_state),       32'd0);
        check("rst_cnt",    32'(hz.ow_stall_cnt),   32'd0);
        check("rst_err",    32'(hz.ow_err),         32'd0);
        tick(); tick();
        rst_n = 1;
        clr_in();
        tick();

        // Load-use on src GP3.
        set_luse(3, 3, 1);
        #1;
        check("lu_stall", 32'(hz.ow_stall_front), 32'd1);
        check("lu_bubble", 32'(hz.ow_bubble_ex),  32'd1);
        tick();
        clr_in();
        #1;
        check("lu_after_stall", 32'(hz.ow_stall_front), 32'd0);
        check("lu_after_cnt",   32'(hz.ow_stall_cnt),   32'd1);
        tick();

        // No hazard: different index, or not a load.
        set_luse(3, 4, 1);
        #1;
        check("nolu_idx", 32'(hz.ow_stall_front | hz.ow_bubble_ex), 32'd0);
        tick();
        set_luse(3, 3, 0);
        #1;
        check("nolu_load", 32'(hz.ow_stall_front | hz.ow_bubble_ex), 32'd0);
        tick();
        clr_in();

        // Branch: three flush cycles, load-use squashed during flush.
        hz.iw_ex_branch_taken = 1;
        #1;
        check("br_flush0", 32'(hz.ow_flush_front), 32'd1);
        tick();
        clr_in();
        set_luse(5, 5, 1);
        #1;
        check("br_flush1", 32'(hz.ow_flush_front), 32'd1);
        check("br_state1", 32'(hz.ow_state),       32'd2);
        check("br_nobub1", 32'(hz.ow_bubble_ex),   32'd0);
        tick();
        #1;
        check("br_flush2", 32'(hz.ow_flush_front), 32'd1);
        check("br_nobub2", 32'(hz.ow_bubble_ex),   32'd0);
        tick();
        #1;
        check("br_flush3", 32'(hz.ow_flush_front), 32'd0);
        check("br_state3", 32'(hz.ow_state),       32'd0);
        check("br_bub3",   32'(hz.ow_bubble_ex),   32'd1);
        tick();
        clr_in();

        // Multi-cycle op completing after 5 cycles.
        stalls = 0;
        for (int i = 0; i < 7; i++) begin
            hz.iw_ex_mc_start = (i == 0);
            hz.iw_ex_mc_done  = (i == 5);
            #1;
            if (hz.ow_stall_front && hz.ow_stall_ex) stalls++;
            if (i == 5) check("mc_done_stall", 32'(hz.ow_stall_front), 32'd0);
            tick();
        end
        clr_in();
        check("mc_stalls", 32'(stalls), 32'd5);
        check("mc_state",  32'(hz.ow_state), 32'd0);

        // Forced release, then again with three memory-wait cycles mid-busy.
        run_mc_timeout(99, 0, 8, 8);
        run_mc_timeout(3, 3, 11, 11);

        // Asynchronous reset in the middle of a multi-cycle op.
        hz.iw_ex_mc_start = 1;
        tick();
        clr_in();
        tick();
        check("mid_busy_state", 32'(hz.ow_state), 32'd1);
        #2;
        rst_n = 0;
        #1;
        check("arst_state", 32'(hz.ow_state),       32'd0);
        check("arst_stall", 32'(hz.ow_stall_front), 32'd0);
        tick();
        rst_n = 1;
        tick();

        // Branch and mc_start together: flush wins, error sticks.
        hz.iw_ex_branch_taken = 1;
        hz.iw_ex_mc_start = 1;
        #1;
        check("both_flush", 32'(hz.ow_flush_front), 32'd1);
        check("both_stall", 32'(hz.ow_stall_front), 32'd0);
        tick();
        clr_in();
        #1;
        check("both_err",   32'(hz.ow_err),   32'd1);
        check("both_state", 32'(hz.ow_state), 32'd2);
        tick(); tick(); tick();
        check("err_sticky", 32'(hz.ow_err), 32'd1);

        // Counter saturation and clear priority.
        set_luse(7, 7, 1);
        for (int i = 0; i < CMAX + 6; i++) tick();
        check("cnt_sat", 32'(hz.ow_stall_cnt), 32'(CMAX));
        hz.iw_cnt_clr = 1;
        tick();
        check("cnt_clr", 32'(hz.ow_stall_cnt), 32'd0);
        clr_in();
        tick();

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            hz.iw_id_src_gp       = GP_IDX_W'($urandom_range(0, 3));
            hz.iw_id_src_gp_re    = $urandom_range(0, 1);
            hz.iw_id_tgt_gp       = GP_IDX_W'($urandom_range(0, 3));
            hz.iw_id_tgt_gp_re    = $urandom_range(0, 1);
            hz.iw_ex_tgt_gp       = GP_IDX_W'($urandom_range(0, 3));
            hz.iw_ex_tgt_gp_we    = ($urandom_range(0, 3) != 0);
            hz.iw_ex_is_load      = $urandom_range(0, 1);
            hz.iw_ex_branch_taken = ($urandom_range(0, 99) < 8);
            hz.iw_ex_mc_start     = ($urandom_range(0, 99) < 8);
            hz.iw_ex_mc_done      = ($urandom_range(0, 99) < 12);
            hz.iw_mem_wait        = ($urandom_range(0, 99) < 10);
            hz.iw_cnt_clr         = ($urandom_range(0, 99) < 2);
            tick();
        end
        rst_n = 1;
        clr_in();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
